// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the regfile writeback arbiter.
// Optional same-cycle bypass is enabled by defining REGFILE_WB_BYPASS_EN.
package regfile_wb_arbiter_pkg;

    localparam int RegAddrWidth = 5;
    localparam int RegWidth     = 32;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    typedef struct packed {
        logic [RegAddrWidth-1:0] addr;
        logic [RegWidth-1:0]     data;
    } wb_entry_t;

    // Round-robin helper: the requester to prefer after granting r.
    function automatic logic other_req(input logic r);
        return ~r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-requester writeback queue: push/pop/full/empty plus per-entry
// address-match vectors used by the pending-write queries.
module wb_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o,
    input  logic [ADDR_W-1:0] match1_addr_i,
    input  logic [ADDR_W-1:0] match2_addr_i,
    output logic [DEPTH-1:0]  match1_o,
    output logic [DEPTH-1:0]  match2_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PW-1:0]     rd_q;
    logic [PW-1:0]     wr_q;
    logic [CW-1:0]     count_q;
    logic              do_push_s;
    logic              do_pop_s;

    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == {CW{1'b0}});
    assign do_push_s   = push_i && !full_o;
    assign do_pop_s    = pop_i && !empty_o;
    assign head_addr_o = addr_q[rd_q];
    assign head_data_o = data_q[rd_q];

    // Pointers, occupancy and per-slot valid bits; power-of-two depth wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= {PW{1'b0}};
            wr_q    <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            valid_q <= {DEPTH{1'b0}};
        end else begin
            if (do_pop_s) begin
                rd_q          <= rd_q + PW'(1);
                valid_q[rd_q] <= 1'b0;
            end
            if (do_push_s) begin
                wr_q          <= wr_q + PW'(1);
                valid_q[wr_q] <= 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; slot contents only matter while the valid bit is set.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            addr_q[wr_q] <= push_addr_i;
            data_q[wr_q] <= push_data_i;
        end
    end

    // Address match per live slot for the decode stall queries.
    always_comb begin
        match1_o = {DEPTH{1'b0}};
        match2_o = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            match1_o[i] = valid_q[i] && (addr_q[i] == match1_addr_i);
            match2_o[i] = valid_q[i] && (addr_q[i] == match2_addr_i);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin writeback arbiter for the single regfile write port.
// Define REGFILE_WB_BYPASS_EN to let an uncontended entry skip its empty queue.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = RegAddrWidth,
    parameter int DATA_W     = RegWidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] query1_addr,
    output logic              query1_pending,
    input  logic [ADDR_W-1:0] query2_addr,
    output logic              query2_pending
);

    logic              alive_q;
    logic              rr_q;
    logic              rr_d;
    logic              wen_q;
    logic              wen_d;
    logic [ADDR_W-1:0] waddr_q;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;

    logic              full0_s, full1_s, empty0_s, empty1_s;
    logic              head0_s, head1_s;
    logic              cand0_s, cand1_s;
    logic              push0_s, push1_s;
    logic              grant0_s, grant1_s;
    logic              byp0_s, byp1_s;
    logic [ADDR_W-1:0] head_addr0_s, head_addr1_s;
    logic [DATA_W-1:0] head_data0_s, head_data1_s;
    logic [FIFO_DEPTH-1:0] m0_q1_s, m0_q2_s, m1_q1_s, m1_q2_s;

    // Ready comes from registered state only, and stays low until the first edge after reset.
    assign req0_ready = alive_q && !full0_s;
    assign req1_ready = alive_q && !full1_s;

    // Writes to r0 complete the handshake but never occupy a slot.
    assign cand0_s = req0_valid && req0_ready && (req0_addr != {ADDR_W{1'b0}});
    assign cand1_s = req1_valid && req1_ready && (req1_addr != {ADDR_W{1'b0}});
    assign head0_s = !empty0_s;
    assign head1_s = !empty1_s;
    assign push0_s = cand0_s && !byp0_s;
    assign push1_s = cand1_s && !byp1_s;

    wb_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo0 (
        .clk(clk), .rst(rst),
        .push_i(push0_s), .push_addr_i(req0_addr), .push_data_i(req0_data),
        .pop_i(grant0_s), .head_addr_o(head_addr0_s), .head_data_o(head_data0_s),
        .full_o(full0_s), .empty_o(empty0_s),
        .match1_addr_i(query1_addr), .match2_addr_i(query2_addr),
        .match1_o(m0_q1_s), .match2_o(m0_q2_s)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo1 (
        .clk(clk), .rst(rst),
        .push_i(push1_s), .push_addr_i(req1_addr), .push_data_i(req1_data),
        .pop_i(grant1_s), .head_addr_o(head_addr1_s), .head_data_o(head_data1_s),
        .full_o(full1_s), .empty_o(empty1_s),
        .match1_addr_i(query1_addr), .match2_addr_i(query2_addr),
        .match1_o(m1_q1_s), .match2_o(m1_q2_s)
    );

    // Round-robin grant over the queue heads; rr_q names the preferred requester.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (head0_s && head1_s) begin
            grant0_s = (rr_q == REQ_ALU);
            grant1_s = (rr_q == REQ_MEM);
        end else begin
            grant0_s = head0_s;
            grant1_s = head1_s;
        end
    end

    // Bypass only when the output path is otherwise idle; contention falls back to rr_q.
    always_comb begin
        byp0_s = 1'b0;
        byp1_s = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
        if (!head0_s && !head1_s) begin
            if (cand0_s && cand1_s) begin
                byp0_s = (rr_q == REQ_ALU);
                byp1_s = (rr_q == REQ_MEM);
            end else begin
                byp0_s = cand0_s;
                byp1_s = cand1_s;
            end
        end else begin
            byp0_s = 1'b0;
            byp1_s = 1'b0;
        end
`else
        byp0_s = 1'b0;
        byp1_s = 1'b0;
`endif
    end

    // Next write-port contents; address/data hold when nothing is granted.
    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rr_d    = rr_q;
        if (grant0_s) begin
            wen_d   = 1'b1;
            waddr_d = head_addr0_s;
            wdata_d = head_data0_s;
            rr_d    = other_req(REQ_ALU);
        end else if (grant1_s) begin
            wen_d   = 1'b1;
            waddr_d = head_addr1_s;
            wdata_d = head_data1_s;
            rr_d    = other_req(REQ_MEM);
        end else if (byp0_s) begin
            wen_d   = 1'b1;
            waddr_d = req0_addr;
            wdata_d = req0_data;
            rr_d    = other_req(REQ_ALU);
        end else if (byp1_s) begin
            wen_d   = 1'b1;
            waddr_d = req1_addr;
            wdata_d = req1_data;
            rr_d    = other_req(REQ_MEM);
        end else begin
            wen_d   = 1'b0;
        end
    end

    // Registered write port and arbitration pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q   <= 1'b0;
            waddr_q <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            rr_q    <= REQ_ALU;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rr_q    <= rr_d;
        end
    end

    // Marks the first cycle after reset release so ready can rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    assign write_en   = wen_q;
    assign write_addr = waddr_q;
    assign write_data = wdata_q;

    assign query1_pending = (query1_addr != {ADDR_W{1'b0}}) &&
                            ((|m0_q1_s) || (|m1_q1_s) || (wen_q && (waddr_q == query1_addr)));
    assign query2_pending = (query2_addr != {ADDR_W{1'b0}}) &&
                            ((|m0_q2_s) || (|m1_q2_s) || (wen_q && (waddr_q == query2_addr)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized
// run against a queue-based reference model. Honours REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

`ifdef REGFILE_WB_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr = 5'd0, req1_addr = 5'd0;
    logic [31:0] req0_data = 32'd0, req1_data = 32'd0;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  query1_addr = 5'd0, query2_addr = 5'd0;
    logic        query1_pending, query2_pending;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: accepted-but-not-yet-retired entries per requester, in order.
    wb_entry_t mq0[$];
    wb_entry_t mq1[$];
    bit  out_flag = 1'b0;
    bit  out_req  = 1'b0;
    int  commits = 0;
    int  enq = 0;
    int  stall0_seen = 0;

    regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .query1_addr(query1_addr), .query1_pending(query1_pending),
        .query2_addr(query2_addr), .query2_pending(query2_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic bit model_pending(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq0[i]) if (mq0[i].addr == a) return 1'b1;
        foreach (mq1[i]) if (mq1[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_q1(input logic [4:0] a);
        foreach (mq1[i]) if (mq1[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_q0(input logic [4:0] a);
        foreach (mq0[i]) if (mq0[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = 5'd0; req1_addr = 5'd0;
        req0_data = 32'd0; req1_data = 32'd0;
        query1_addr = 5'd0; query2_addr = 5'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        mq0.delete(); mq1.delete(); out_flag = 1'b0;
    endtask

    // One model-checked cycle; entered and left at posedge+1.
    task automatic step(input bit v0, input bit v1);
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        int n0, n1;
        bit er0, er1, acc0, acc1, busy;
        wb_entry_t e;
        a0 = 5'($urandom_range(0, 15));
        a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
        d0 = $urandom; d1 = $urandom;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        query1_addr = 5'($urandom_range(0, 31));
        query2_addr = (mq1.size() > 0 && $urandom_range(0, 1) == 1) ? mq1[0].addr : 5'($urandom_range(0, 31));
        #1;
        n0 = mq0.size() - ((out_flag && out_req == 1'b0) ? 1 : 0);
        n1 = mq1.size() - ((out_flag && out_req == 1'b1) ? 1 : 0);
        er0 = (n0 < DEPTH);
        er1 = (n1 < DEPTH);
        total_cnt++; if (req0_ready !== er0) $display("FAIL rnd_ready0 got=%0b exp=%0b", req0_ready, er0); else pass_cnt++;
        total_cnt++; if (req1_ready !== er1) $display("FAIL rnd_ready1 got=%0b exp=%0b", req1_ready, er1); else pass_cnt++;
        total_cnt++; if (query1_pending !== model_pending(query1_addr)) $display("FAIL rnd_pend1 addr=%0d got=%0b exp=%0b", query1_addr, query1_pending, model_pending(query1_addr)); else pass_cnt++;
        total_cnt++; if (query2_pending !== model_pending(query2_addr)) $display("FAIL rnd_pend2 addr=%0d got=%0b exp=%0b", query2_addr, query2_pending, model_pending(query2_addr)); else pass_cnt++;
        if (v0 && !er0) stall0_seen++;
        acc0 = v0 && er0;
        acc1 = v1 && er1;
        busy = (n0 + n1) > 0;
        if (acc0 && a0 != 5'd0) assert (!in_q1(a0)) else $error("same address live in both queues");
        if (acc1 && a1 != 5'd0) assert (!in_q0(a1)) else $error("same address live in both queues");
        @(posedge clk); #1;
        if (out_flag) begin
            if (out_req) void'(mq1.pop_front());
            else void'(mq0.pop_front());
            out_flag = 1'b0;
            commits++;
        end
        if (acc0 && a0 != 5'd0) begin mq0.push_back('{addr: a0, data: d0}); enq++; end
        if (acc1 && a1 != 5'd0) begin mq1.push_back('{addr: a1, data: d1}); enq++; end
        if (busy) begin
            total_cnt++; if (write_en !== 1'b1) $display("FAIL rnd_idle_with_work got=%0b exp=1", write_en); else pass_cnt++;
        end
        if (write_en === 1'b1) begin
            e = '{addr: 5'd0, data: 32'd0};
            if (mq0.size() > 0 && mq0[0].addr == write_addr) begin out_flag = 1'b1; out_req = 1'b0; e = mq0[0]; end
            else if (mq1.size() > 0 && mq1[0].addr == write_addr) begin out_flag = 1'b1; out_req = 1'b1; e = mq1[0]; end
            total_cnt++; if (out_flag !== 1'b1) $display("FAIL rnd_write_order addr=%0d got=unexpected exp=queue_head", write_addr); else pass_cnt++;
            if (out_flag) begin
                total_cnt++; if (write_data !== e.data) $display("FAIL rnd_write_data addr=%0d got=%h exp=%h", write_addr, write_data, e.data); else pass_cnt++;
            end
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 30 && (mq0.size() > 0 || mq1.size() > 0); c++) step(1'b0, 1'b0);
        total_cnt++; if ((mq0.size() + mq1.size()) !== 0) $display("FAIL drain_left got=%0d exp=0", mq0.size() + mq1.size()); else pass_cnt++;
        total_cnt++; if (commits !== enq) $display("FAIL drain_commits got=%0d exp=%0d", commits, enq); else pass_cnt++;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++; if (write_en !== 1'b0) $display("FAIL reset_wen got=%0b exp=0", write_en); else pass_cnt++;
        total_cnt++; if (write_addr !== 5'd0) $display("FAIL reset_waddr got=%0d exp=0", write_addr); else pass_cnt++;
        total_cnt++; if (write_data !== 32'd0) $display("FAIL reset_wdata got=%h exp=0", write_data); else pass_cnt++;
        total_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL reset_ready_in_rst got=%0b%0b exp=00", req0_ready, req1_ready); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) $display("FAIL reset_ready_after got=%0b%0b exp=11", req0_ready, req1_ready); else pass_cnt++;
        total_cnt++; if (write_en !== 1'b0) $display("FAIL reset_wen_after got=%0b exp=0", write_en); else pass_cnt++;
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hDEADBEEF; query1_addr = 5'd3;
        #1;
        total_cnt++; if (query1_pending !== 1'b0) $display("FAIL single_pend_before got=%0b exp=0", query1_pending); else pass_cnt++;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        for (int c = 0; c < LAT; c++) begin
            total_cnt++; if (write_en !== 1'b0) $display("FAIL single_wen_early got=%0b exp=0", write_en); else pass_cnt++;
            total_cnt++; if (query1_pending !== 1'b1) $display("FAIL single_pend_queued got=%0b exp=1", query1_pending); else pass_cnt++;
            @(posedge clk); #1;
        end
        total_cnt++; if (write_en !== 1'b1) $display("FAIL single_wen got=%0b exp=1", write_en); else pass_cnt++;
        total_cnt++; if (write_addr !== 5'd3) $display("FAIL single_waddr got=%0d exp=3", write_addr); else pass_cnt++;
        total_cnt++; if (write_data !== 32'hDEADBEEF) $display("FAIL single_wdata got=%h exp=deadbeef", write_data); else pass_cnt++;
        total_cnt++; if (query1_pending !== 1'b1) $display("FAIL single_pend_out got=%0b exp=1", query1_pending); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (write_en !== 1'b0) $display("FAIL single_wen_off got=%0b exp=0", write_en); else pass_cnt++;
        total_cnt++; if (write_addr !== 5'd3) $display("FAIL single_addr_hold got=%0d exp=3", write_addr); else pass_cnt++;
        total_cnt++; if (query1_pending !== 1'b0) $display("FAIL single_pend_after got=%0b exp=0", query1_pending); else pass_cnt++;
    endtask

    task automatic test_addr0();
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234; query1_addr = 5'd0; query2_addr = 5'd0;
        #1;
        total_cnt++; if (req1_ready !== 1'b1) $display("FAIL addr0_ready got=%0b exp=1", req1_ready); else pass_cnt++;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total_cnt++; if (write_en !== 1'b0) $display("FAIL addr0_wen got=%0b exp=0", write_en); else pass_cnt++;
            total_cnt++; if (query1_pending !== 1'b0 || query2_pending !== 1'b0) $display("FAIL addr0_pend got=%0b%0b exp=00", query1_pending, query2_pending); else pass_cnt++;
            @(posedge clk); #1;
        end
        total_cnt++; if (req1_ready !== 1'b1) $display("FAIL addr0_not_enqueued got=%0b exp=1", req1_ready); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] a0 [4];
        logic [4:0] a1 [4];
        logic [4:0] exp_order [8];
        logic [4:0] obs[$];
        int i0, i1, gap;
        bit started, acc0, acc1;
        a0 = '{5'd1, 5'd2, 5'd3, 5'd4};
        a1 = '{5'd5, 5'd6, 5'd7, 5'd8};
        exp_order = '{5'd1, 5'd5, 5'd2, 5'd6, 5'd3, 5'd7, 5'd4, 5'd8};
        i0 = 0; i1 = 0; gap = 0; started = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 40 && obs.size() < 8; cyc++) begin
            req0_valid = (i0 < 4); req0_addr = (i0 < 4) ? a0[i0] : 5'd0; req0_data = 32'hA000_0000 + 32'(i0);
            req1_valid = (i1 < 4); req1_addr = (i1 < 4) ? a1[i1] : 5'd0; req1_data = 32'hB000_0000 + 32'(i1);
            #1;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (acc0) i0++;
            if (acc1) i1++;
            if (write_en === 1'b1) begin started = 1'b1; obs.push_back(write_addr); end
            else if (started) gap++;
        end
        idle_inputs();
        total_cnt++; if (obs.size() !== 8) $display("FAIL b2b_count got=%0d exp=8", obs.size()); else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            if (k < obs.size()) begin
                total_cnt++; if (obs[k] !== exp_order[k]) $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", k, obs[k], exp_order[k]); else pass_cnt++;
            end
        end
        total_cnt++; if (gap !== 0) $display("FAIL b2b_gaps got=%0d exp=0", gap); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req0_valid = 1'b1; req0_addr = 5'(9 + k);  req0_data = 32'hC0 + 32'(k);
            req1_valid = 1'b1; req1_addr = 5'(20 + k); req1_data = 32'hD0 + 32'(k);
            @(posedge clk); #1;
        end
        idle_inputs();
        query1_addr = 5'd11; query2_addr = 5'd21;
        #1;
        total_cnt++; if (query1_pending !== 1'b1 || query2_pending !== 1'b1) $display("FAIL mid_pend_before got=%0b%0b exp=11", query1_pending, query2_pending); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (write_en !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'd0) $display("FAIL mid_outputs got=%0b/%0d/%h exp=0/0/0", write_en, write_addr, write_data); else pass_cnt++;
        total_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL mid_ready_in_rst got=%0b%0b exp=00", req0_ready, req1_ready); else pass_cnt++;
        total_cnt++; if (query1_pending !== 1'b0 || query2_pending !== 1'b0) $display("FAIL mid_pend_flushed got=%0b%0b exp=00", query1_pending, query2_pending); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) $display("FAIL mid_ready_after got=%0b%0b exp=11", req0_ready, req1_ready); else pass_cnt++;
        for (int c = 0; c < 4; c++) begin
            total_cnt++; if (write_en !== 1'b0) $display("FAIL mid_no_write cyc=%0d got=%0b exp=0", c, write_en); else pass_cnt++;
            @(posedge clk); #1;
        end
        mq0.delete(); mq1.delete(); out_flag = 1'b0;
    endtask

    task automatic test_starve();
        do_reset();
        stall0_seen = 0;
        for (int c = 0; c < 30; c++) step(1'b1, 1'b1);
        total_cnt++; if (stall0_seen == 0) $display("FAIL starve_ready0_drop got=0 exp=nonzero"); else pass_cnt++;
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_addr0();
        test_back_to_back();
        test_reset_mid();
        test_starve();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
